// File: rtl/decode_system_pipe_pkg.sv
// Shared types for the SYSTEM-opcode decode pipe: decoded kinds, the queued record layout and the opcode constant.
package decode_system_pipe_pkg;

  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  // Record tag field is sized for the widest tag any instance may carry; instances use the low TAG_W bits.
  localparam int         SYS_TAG_MAX = 16;

  typedef enum logic [3:0] {
    sysk_invalid = 4'd0,
    sysk_ecall   = 4'd1,
    sysk_ebreak  = 4'd2,
    sysk_csrrw   = 4'd3,
    sysk_csrrs   = 4'd4,
    sysk_csrrc   = 4'd5,
    sysk_csrrwi  = 4'd6,
    sysk_csrrsi  = 4'd7,
    sysk_csrrci  = 4'd8,
    sysk_mret    = 4'd9,
    sysk_sret    = 4'd10,
    sysk_wfi     = 4'd11
  } system_kind_t;

  typedef struct packed {
    system_kind_t           kind;
    logic [11:0]            csr;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [SYS_TAG_MAX-1:0] tag;
    logic                   illegal;
  } sys_decoded_t;

  // Records that must serialise the front end until the trap handler acknowledges.
  function automatic logic is_trap(sys_decoded_t d);
    return d.illegal || (d.kind == sysk_ecall) || (d.kind == sysk_ebreak) ||
           (d.kind == sysk_mret) || (d.kind == sysk_sret);
  endfunction

endpackage

// File: rtl/decode_system_pipe_if.sv
// Handshake bundle between the front end (master) and the SYSTEM decode pipe (slave).
interface decode_system_pipe_if #(parameter int TAG_W = 4);
  import decode_system_pipe_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  system_kind_t     out_kind;
  logic [11:0]      out_csr;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic             hold;
  logic             trap_ack;
  logic             flush;

  modport master (
    output in_valid, in_instr, in_tag, out_ready, trap_ack, flush,
    input  in_ready, out_valid, out_kind, out_csr, out_rd, out_rs1, out_tag, out_illegal, hold
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready, trap_ack, flush,
    output in_ready, out_valid, out_kind, out_csr, out_rd, out_rs1, out_tag, out_illegal, hold
  );

endinterface

// File: rtl/decode_system_pipe_comb.sv
// Pure combinational SYSTEM instruction decoder. DECODE_SYSTEM_PRIV_EN adds mret/sret/wfi decoding.
module decode_system_comb
  import decode_system_pipe_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] tag,
  output sys_decoded_t     dec
);

  logic [24:0] upper;
  assign upper = instr[31:7];

  always_comb begin
    dec         = '0;
    dec.csr     = instr[31:20];
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.tag     = SYS_TAG_MAX'(tag);
    dec.kind    = sysk_invalid;
    dec.illegal = 1'b1;
    if (instr[6:0] == OPC_SYSTEM) begin
      case (instr[14:12])
        3'b000: begin
          // Privileged forms need rs1=rd=0, so the whole instr[31:7] field is matched exactly.
          if (upper == 25'd0) begin
            dec.kind = sysk_ecall;  dec.illegal = 1'b0;
          end else if (upper == {12'h001, 13'd0}) begin
            dec.kind = sysk_ebreak; dec.illegal = 1'b0;
          end
`ifdef DECODE_SYSTEM_PRIV_EN
          else if (upper == {12'h302, 13'd0}) begin
            dec.kind = sysk_mret;   dec.illegal = 1'b0;
          end else if (upper == {12'h102, 13'd0}) begin
            dec.kind = sysk_sret;   dec.illegal = 1'b0;
          end else if (upper == {12'h105, 13'd0}) begin
            dec.kind = sysk_wfi;    dec.illegal = 1'b0;
          end
`endif
        end
        3'b001: begin dec.kind = sysk_csrrw;  dec.illegal = 1'b0; end
        3'b010: begin dec.kind = sysk_csrrs;  dec.illegal = 1'b0; end
        3'b011: begin dec.kind = sysk_csrrc;  dec.illegal = 1'b0; end
        3'b101: begin dec.kind = sysk_csrrwi; dec.illegal = 1'b0; end
        3'b110: begin dec.kind = sysk_csrrsi; dec.illegal = 1'b0; end
        3'b111: begin dec.kind = sysk_csrrci; dec.illegal = 1'b0; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_system_pipe.sv
// Buffered SYSTEM-opcode decoder: decode, DEPTH-entry FIFO toward execute, RUN/HOLD trap serialisation.
// Build with DECODE_SYSTEM_PRIV_EN defined to decode mret/sret/wfi (see decode_system_comb).
module decode_system_pipe
  import decode_system_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  decode_system_pipe_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN, HOLD} state_t;

  state_t       state;
  sys_decoded_t dec, head;
  sys_decoded_t mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  decode_system_comb #(.TAG_W(TAG_W)) u_dec (
    .instr (bus.in_instr),
    .tag   (bus.in_tag),
    .dec   (dec)
  );

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  // A full FIFO refuses pushes even when the head is popping this cycle.
  assign bus.in_ready = !full && (state == RUN) && !bus.flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = !empty && bus.out_ready;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      state <= RUN;
    end else if (bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      state <= RUN;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case (state)
        RUN:  if (push && is_trap(dec)) state <= HOLD;
        HOLD: if (bus.trap_ack)         state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible unless count says the slot is live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dec;
  end

  assign head            = empty ? '0 : mem[rptr];
  assign bus.out_valid   = !empty;
  assign bus.out_kind    = head.kind;
  assign bus.out_csr     = head.csr;
  assign bus.out_rd      = head.rd;
  assign bus.out_rs1     = head.rs1;
  assign bus.out_tag     = head.tag[TAG_W-1:0];
  assign bus.out_illegal = head.illegal;
  assign bus.hold        = (state == HOLD);

  logic unused_tag_hi;
  assign unused_tag_hi = ^head.tag;

endmodule

// File: tb/tb_decode_system_pipe.sv
// Scoreboarded bench for decode_system_pipe: directed scenarios plus randomized traffic against a word-level model.
module tb_decode_system_pipe;
  import decode_system_pipe_pkg::*;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_system_pipe_if #(.TAG_W(TAG_W)) bus();
  decode_system_pipe #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    system_kind_t     kind;
    logic [11:0]      csr;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [TAG_W-1:0] tag;
    bit               illegal;
    bit               trap;
  } exp_t;

  exp_t q[$];
  bit   mhold;
  int   checks = 0;
  int   errors = 0;

  system_kind_t csr_kind [8] = '{sysk_invalid, sysk_csrrw, sysk_csrrs, sysk_csrrc,
                                 sysk_invalid, sysk_csrrwi, sysk_csrrsi, sysk_csrrci};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: whole-word matching for the fixed privileged encodings, table lookup for CSR ops.
  function automatic exp_t model(input logic [31:0] w, input logic [TAG_W-1:0] t);
    exp_t e;
    e.csr = w[31:20]; e.rd = w[11:7]; e.rs1 = w[19:15]; e.tag = t;
    e.kind = sysk_invalid; e.illegal = 1'b1;
    if (w[6:0] == 7'h73) begin
      if (csr_kind[w[14:12]] != sysk_invalid) begin
        e.kind = csr_kind[w[14:12]]; e.illegal = 1'b0;
      end else if (w == 32'h0000_0073) begin
        e.kind = sysk_ecall; e.illegal = 1'b0;
      end else if (w == 32'h0010_0073) begin
        e.kind = sysk_ebreak; e.illegal = 1'b0;
      end
`ifdef DECODE_SYSTEM_PRIV_EN
      else if (w == 32'h3020_0073) begin e.kind = sysk_mret; e.illegal = 1'b0; end
      else if (w == 32'h1020_0073) begin e.kind = sysk_sret; e.illegal = 1'b0; end
      else if (w == 32'h1050_0073) begin e.kind = sysk_wfi;  e.illegal = 1'b0; end
`endif
    end
    e.trap = e.illegal || e.kind inside {sysk_ecall, sysk_ebreak, sysk_mret, sysk_sret};
    return e;
  endfunction

  // Monitor: checks handshake/hold against the model every cycle, pops on output handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   er;
    if (!rst) begin
      q.delete();
      mhold = 1'b0;
    end else begin
      er = (q.size() < DEPTH) && !mhold && !bus.flush;
      chk("in_ready",  32'(bus.in_ready),  32'(er));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("hold",      32'(bus.hold),      32'(mhold));
      if (q.size() != 0 && bus.out_ready && !bus.flush) begin
        e = q.pop_front();
        chk("kind",    32'(bus.out_kind),    32'(e.kind));
        chk("csr",     32'(bus.out_csr),     32'(e.csr));
        chk("rd",      32'(bus.out_rd),      32'(e.rd));
        chk("rs1",     32'(bus.out_rs1),     32'(e.rs1));
        chk("tag",     32'(bus.out_tag),     32'(e.tag));
        chk("illegal", 32'(bus.out_illegal), 32'(e.illegal));
      end
      if (bus.flush) begin
        q.delete();
        mhold = 1'b0;
      end else if (bus.in_valid && er) begin
        e = model(bus.in_instr, bus.in_tag);
        q.push_back(e);
        if (e.trap) mhold = 1'b1;
      end else if (mhold && bus.trap_ack) begin
        mhold = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [TAG_W-1:0] t);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_instr = w; bus.in_tag = t;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    chk("send_accept", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.trap_ack = 1'b1; step(); bus.trap_ack = 1'b0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    logic [2:0]  f3s [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    logic [31:0] priv [3] = '{32'h3020_0073, 32'h1020_0073, 32'h1050_0073};
    case ($urandom_range(0, 9))
      0: w = 32'h0000_0073;
      1: w = 32'h0010_0073;
      2: w = priv[$urandom_range(0, 2)];
      3: begin w[6:0] = 7'h73; w[14:12] = 3'b100; end
      4: ;
      5: begin w[6:0] = 7'h73; w[14:12] = 3'b000; end
      default: begin w[6:0] = 7'h73; w[14:12] = f3s[$urandom_range(0, 5)]; end
    endcase
    return w;
  endfunction

  initial begin : stim
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1; bus.trap_ack = 1'b0; bus.flush = 1'b0;

    // Reset values
    #12;
    chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
    chk("rst_hold",      32'(bus.hold),        32'd0);
    chk("rst_kind",      32'(bus.out_kind),    32'(sysk_invalid));
    chk("rst_csr",       32'(bus.out_csr),     32'd0);
    chk("rst_illegal",   32'(bus.out_illegal), 32'd0);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // csrrw, next-cycle visibility
    send(32'h3001_10F3, 4'd3);
    @(negedge clk);
    chk("csrrw_valid", 32'(bus.out_valid), 32'd1);
    chk("csrrw_kind",  32'(bus.out_kind),  32'(sysk_csrrw));
    chk("csrrw_csr",   32'(bus.out_csr),   32'h300);
    chk("csrrw_rd",    32'(bus.out_rd),    32'd1);
    chk("csrrw_rs1",   32'(bus.out_rs1),   32'd2);
    chk("csrrw_tag",   32'(bus.out_tag),   32'd3);
    chk("csrrw_hold",  32'(bus.hold),      32'd0);
    step();

    // ecall holds the front end until trap_ack
    send(32'h0000_0073, 4'd5);
    @(negedge clk);
    chk("ecall_hold",  32'(bus.hold),     32'd1);
    chk("ecall_ready", 32'(bus.in_ready), 32'd0);
    step(); step(); step();
    @(negedge clk);
    chk("ecall_ready_late", 32'(bus.in_ready), 32'd0);
    step();
    ack_pulse();
    @(negedge clk);
    chk("ack_ready", 32'(bus.in_ready), 32'd1);
    chk("ack_hold",  32'(bus.hold),     32'd0);
    step();

    // funct3=100 illegal, then flush
    bus.out_ready = 1'b0;
    send(32'h0000_4073, 4'd6);
    @(negedge clk);
    chk("ill_kind",    32'(bus.out_kind),    32'(sysk_invalid));
    chk("ill_illegal", 32'(bus.out_illegal), 32'd1);
    chk("ill_hold",    32'(bus.hold),        32'd1);
    step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_hold",  32'(bus.hold),      32'd0);
    step();

    // Fill DEPTH=2 with out_ready low, third waits
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_instr = {12'h340, 5'd4, 3'b010, 5'(i + 1), 7'h73};
      bus.in_tag   = 4'(i + 8);
      @(negedge clk);
      if (i == 2) chk("full_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 10) begin @(negedge clk); n++; end
      chk("third_accept", 32'(bus.in_ready), 32'd1);
    end
    step();
    bus.in_valid = 1'b0;
    step(); step();

    // Privileged encodings (macro-dependent kind/hold handled by the model)
    send(32'h3020_0073, 4'd7);
    step(); ack_pulse();
    send(32'h1050_0073, 4'd8);
    step(); ack_pulse();
    step();

    // Async reset with two records queued
    bus.out_ready = 1'b0;
    send(32'h3001_10F3, 4'd1);
    send(32'h3402_20F3, 4'd2);
    #2;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_ready", 32'(bus.in_ready),  32'd1);
    step(); step();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.in_instr  = gen_instr();
      bus.in_tag    = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < 70);
      bus.trap_ack  = ($urandom_range(0, 99) < 25);
      bus.flush     = ($urandom_range(0, 59) == 0);
      step();
    end

    // Drain
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1; bus.trap_ack = 1'b1;
    repeat (DEPTH + 4) step();
    bus.trap_ack = 1'b0;
    @(negedge clk);
    chk("drained", 32'(q.size()), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
